// File: rtl/pipe_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : pipe_ctrl_if
// Purpose  : Bundle of request inputs and sequencing outputs exchanged between
//            the pipeline stages and the pipeline sequencer (pipe_ctrl).
// Signals  : stallreq_id/ex/mem  stage stall requests
//            br_flag/br_addr     taken branch and target from ID
//            exc_req/exc_addr    exception pulse and handler address
//            timeout_clr         clears the sticky watchdog flag
//            stall[5:0]          per-stage hold ([0]=PC ... [5]=WB)
//            flush               flush all pipeline registers
//            b_flag/b_addr       PC redirect valid / target
//            pend_valid          branch target held awaiting PC release
//            stall_timeout       sticky watchdog flag
// Modports : master - pipeline side (drives requests, observes controls)
//            slave  - sequencer side
// Revision : 1.0  initial release
// ============================================================================
interface pipe_ctrl_if;
    logic        stallreq_id;
    logic        stallreq_ex;
    logic        stallreq_mem;
    logic        br_flag;
    logic [31:0] br_addr;
    logic        exc_req;
    logic [31:0] exc_addr;
    logic        timeout_clr;
    logic [5:0]  stall;
    logic        flush;
    logic        b_flag;
    logic [31:0] b_addr;
    logic        pend_valid;
    logic        stall_timeout;

    modport master (
        output stallreq_id, stallreq_ex, stallreq_mem,
        output br_flag, br_addr, exc_req, exc_addr, timeout_clr,
        input  stall, flush, b_flag, b_addr, pend_valid, stall_timeout
    );

    modport slave (
        input  stallreq_id, stallreq_ex, stallreq_mem,
        input  br_flag, br_addr, exc_req, exc_addr, timeout_clr,
        output stall, flush, b_flag, b_addr, pend_valid, stall_timeout
    );
endinterface
`default_nettype wire

// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_ctrl
// Purpose  : Pipeline sequencer for the 5-stage core. Merges stage stall
//            requests into a per-stage stall vector, drives the PC redirect
//            pair, issues exception flushes, holds a branch target that
//            arrives while the PC is frozen and replays it on release, applies
//            a post-reset boot hold and runs a stall watchdog.
// Ports    : clk   - clock, all logic on the rising edge
//            rst   - synchronous reset, active-low
//            ctrl  - pipe_ctrl_if.slave (requests in, sequencing controls out)
// Params   : BOOT_CYCLES - full-stall cycles after reset release (0 = none)
//            MAX_STALL   - consecutive PC-stalled RUN cycles before the
//                          watchdog flag sets (>= 1)
// Revision : 1.0  initial release
// ============================================================================
module pipe_ctrl #(
    parameter int BOOT_CYCLES = 2,
    parameter int MAX_STALL   = 64
) (
    input  wire logic   clk,
    input  wire logic   rst,
    pipe_ctrl_if.slave  ctrl
);

    localparam int BCW = (BOOT_CYCLES < 1) ? 1 : $clog2(BOOT_CYCLES + 1);
    localparam int SCW = (MAX_STALL   < 1) ? 1 : $clog2(MAX_STALL + 1);

    localparam logic [BCW-1:0] BOOT_LOAD = BCW'(BOOT_CYCLES);
    localparam logic [SCW-1:0] STALL_SAT = SCW'(MAX_STALL);
    localparam logic [SCW-1:0] STALL_PRE = SCW'(MAX_STALL - 1);

    localparam logic [5:0] STALL_ALL  = 6'h3F;
    localparam logic [5:0] STALL_MEM  = 6'h1F;
    localparam logic [5:0] STALL_EX   = 6'h0F;
    localparam logic [5:0] STALL_ID   = 6'h07;
    localparam logic [5:0] STALL_NONE = 6'h00;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    // With no boot hold configured, reset lands straight in RUN.
    localparam state_t RESET_STATE = (BOOT_CYCLES == 0) ? ST_RUN : ST_BOOT;

    state_t          state_q;
    logic [BCW-1:0]  boot_cnt_q;
    logic            pend_valid_q;
    logic [31:0]     pend_addr_q;
    logic [31:0]     exc_q;
    logic [SCW-1:0]  stall_cnt_q;
    logic            timeout_q;

    logic [5:0]      run_stall;
    logic            pc_stalled;
    logic            wd_hit;
    logic [5:0]      stall_d;
    logic            flush_d;
    logic            b_flag_d;
    logic [31:0]     b_addr_d;

    // Stall vector a RUN cycle would present: a stage stall also holds every
    // stage upstream of it, so the deepest requester wins.
    always_comb begin
        run_stall = STALL_NONE;
        if (ctrl.stallreq_mem) begin
            run_stall = STALL_MEM;
        end else if (ctrl.stallreq_ex) begin
            run_stall = STALL_EX;
        end else if (ctrl.stallreq_id) begin
            run_stall = STALL_ID;
        end
    end

    assign pc_stalled = (state_q == ST_RUN) && run_stall[0];

    // Counter sits one below the limit and the PC is still frozen: this edge
    // is the one where the stall run reaches MAX_STALL.
    assign wd_hit = pc_stalled && (stall_cnt_q == STALL_PRE);

    // Output decode. While rst is low the outputs show the BOOT values even
    // before the first edge has loaded the state register.
    always_comb begin
        stall_d  = STALL_ALL;
        flush_d  = 1'b0;
        b_flag_d = 1'b0;
        b_addr_d = 32'h0;
        if (rst) begin
            case (state_q)
                ST_RUN: begin
                    stall_d = run_stall;
                    if (!run_stall[0]) begin
                        // A live branch is newer than any held target.
                        if (ctrl.br_flag) begin
                            b_flag_d = 1'b1;
                            b_addr_d = ctrl.br_addr;
                        end else if (pend_valid_q) begin
                            b_flag_d = 1'b1;
                            b_addr_d = pend_addr_q;
                        end
                    end
                end
                ST_FLUSH: begin
                    stall_d  = STALL_NONE;
                    flush_d  = 1'b1;
                    b_flag_d = 1'b1;
                    b_addr_d = exc_q;
                end
                default: begin
                    stall_d = STALL_ALL;
                end
            endcase
        end
    end

    assign ctrl.stall         = stall_d;
    assign ctrl.flush         = flush_d;
    assign ctrl.b_flag        = b_flag_d;
    assign ctrl.b_addr        = b_addr_d;
    assign ctrl.pend_valid    = rst & pend_valid_q;
    assign ctrl.stall_timeout = rst & timeout_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= RESET_STATE;
            boot_cnt_q   <= BOOT_LOAD;
            pend_valid_q <= 1'b0;
            pend_addr_q  <= 32'h0;
            exc_q        <= 32'h0;
            stall_cnt_q  <= '0;
            timeout_q    <= 1'b0;
        end else begin
            // Watchdog: counts only consecutive PC-frozen RUN cycles and
            // saturates so the flag can be cleared during a long stall
            // without immediately re-arming.
            if (pc_stalled) begin
                if (stall_cnt_q != STALL_SAT) begin
                    stall_cnt_q <= stall_cnt_q + SCW'(1);
                end
            end else begin
                stall_cnt_q <= '0;
            end

            if (ctrl.timeout_clr) begin
                timeout_q <= 1'b0;
            end else if (wd_hit) begin
                timeout_q <= 1'b1;
            end

            case (state_q)
                ST_BOOT: begin
                    if (boot_cnt_q != '0) begin
                        boot_cnt_q <= boot_cnt_q - BCW'(1);
                    end
                    if (boot_cnt_q <= BCW'(1)) begin
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (ctrl.exc_req) begin
                        // Exception outranks any branch or held target.
                        exc_q        <= ctrl.exc_addr;
                        pend_valid_q <= 1'b0;
                        state_q      <= ST_FLUSH;
                    end else if (run_stall[0] && ctrl.br_flag) begin
                        // PC frozen: keep the most recent target for replay.
                        pend_valid_q <= 1'b1;
                        pend_addr_q  <= ctrl.br_addr;
                    end else if (!run_stall[0] && (ctrl.br_flag || pend_valid_q)) begin
                        // Redirect consumed this cycle.
                        pend_valid_q <= 1'b0;
                    end
                end
                ST_FLUSH: begin
                    if (ctrl.exc_req) begin
                        exc_q <= ctrl.exc_addr;
                    end else begin
                        state_q <= ST_RUN;
                    end
                end
                default: begin
                    state_q    <= RESET_STATE;
                    boot_cnt_q <= BOOT_LOAD;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_ctrl
// Purpose  : Self-checking bench for pipe_ctrl. Directed scenarios followed by
//            randomized traffic, all compared every cycle against a
//            behavioural model of the sequencer kept in this file.
// Revision : 1.0  initial release
// ============================================================================
module tb_pipe_ctrl;

    localparam int BOOT = 2;
    localparam int MAXS = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    pipe_ctrl_if bus ();

    pipe_ctrl #(
        .BOOT_CYCLES (BOOT),
        .MAX_STALL   (MAXS)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .ctrl (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Behavioural model: boot cycles still owed, whether this cycle is the
    // flush cycle, the held branch target and the current stall run length.
    int          m_boot_left = 0;
    bit          m_in_flush  = 1'b0;
    logic [31:0] m_exc_addr  = '0;
    bit          m_pend      = 1'b0;
    logic [31:0] m_pend_addr = '0;
    int          m_run_len   = 0;
    bit          m_timeout   = 1'b0;

    // Last sampled DUT outputs, for literal checks in the directed steps.
    logic [5:0]  o_stall;
    logic        o_flush, o_bf, o_pv, o_to;
    logic [31:0] o_ba;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit id, input bit ex, input bit mem, input bit br,
                         input logic [31:0] ba, input bit exc, input logic [31:0] ea,
                         input bit clr);
        bus.stallreq_id  = id;
        bus.stallreq_ex  = ex;
        bus.stallreq_mem = mem;
        bus.br_flag      = br;
        bus.br_addr      = ba;
        bus.exc_req      = exc;
        bus.exc_addr     = ea;
        bus.timeout_clr  = clr;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 32'h0, 0, 32'h0, 0);
    endtask

    // One clock: check outputs at the falling edge, advance the model at the
    // rising edge, release 1 time unit later for the next stimulus.
    task automatic cycle();
        logic [5:0]  e_stall;
        logic        e_flush, e_bf;
        logic [31:0] e_ba;
        int          depth;
        bit          pc_st, hit;
        @(negedge clk);
        e_stall = 6'h3F; e_flush = 1'b0; e_bf = 1'b0; e_ba = 32'h0;
        pc_st   = 1'b0;
        if (rst && m_boot_left == 0) begin
            if (m_in_flush) begin
                e_stall = 6'h00; e_flush = 1'b1; e_bf = 1'b1; e_ba = m_exc_addr;
            end else begin
                // Number of held stages, counted from the PC upward.
                depth = bus.stallreq_mem ? 5 : bus.stallreq_ex ? 4 : bus.stallreq_id ? 3 : 0;
                e_stall = 6'((32'd1 << depth) - 1);
                pc_st   = (depth != 0);
                if (!pc_st && bus.br_flag) begin
                    e_bf = 1'b1; e_ba = bus.br_addr;
                end else if (!pc_st && m_pend) begin
                    e_bf = 1'b1; e_ba = m_pend_addr;
                end
            end
        end
        o_stall = bus.stall; o_flush = bus.flush; o_bf = bus.b_flag;
        o_ba    = bus.b_addr; o_pv = bus.pend_valid; o_to = bus.stall_timeout;
        chk("stall",         32'(o_stall), 32'(e_stall));
        chk("flush",         32'(o_flush), 32'(e_flush));
        chk("b_flag",        32'(o_bf),    32'(e_bf));
        chk("b_addr",        o_ba,         e_ba);
        chk("pend_valid",    32'(o_pv),    32'(rst & m_pend));
        chk("stall_timeout", 32'(o_to),    32'(rst & m_timeout));
        @(posedge clk);
        hit = 1'b0;
        if (!rst) begin
            m_boot_left = BOOT; m_in_flush = 1'b0; m_pend = 1'b0;
            m_exc_addr  = '0;   m_run_len  = 0;    m_timeout = 1'b0;
        end else begin
            if (m_boot_left > 0) begin
                m_boot_left--;
                m_run_len = 0;
            end else if (m_in_flush) begin
                if (bus.exc_req) m_exc_addr = bus.exc_addr;
                else             m_in_flush = 1'b0;
                m_run_len = 0;
            end else begin
                if (pc_st) begin
                    if (m_run_len < MAXS) begin
                        m_run_len++;
                        hit = (m_run_len == MAXS);
                    end
                end else begin
                    m_run_len = 0;
                end
                if (bus.exc_req) begin
                    m_in_flush = 1'b1; m_exc_addr = bus.exc_addr; m_pend = 1'b0;
                end else if (pc_st && bus.br_flag) begin
                    m_pend = 1'b1; m_pend_addr = bus.br_addr;
                end else if (!pc_st && (bus.br_flag || m_pend)) begin
                    m_pend = 1'b0;
                end
            end
            if (bus.timeout_clr) m_timeout = 1'b0;
            else if (hit)        m_timeout = 1'b1;
        end
        #1;
    endtask

    initial begin
        idle();
        rst = 1'b0;

        // Boot: three reset cycles, then two full-stall cycles, then free.
        repeat (3) cycle();
        rst = 1'b1;
        cycle(); chk("boot_stall0", 32'(o_stall), 32'h3F);
        cycle(); chk("boot_stall1", 32'(o_stall), 32'h3F);
        cycle(); chk("boot_run",    32'(o_stall), 32'h00);
        chk("boot_bflag", 32'(o_bf), 32'h0);

        // Stall encoding.
        drive(1, 0, 0, 0, 0, 0, 0, 0); cycle(); chk("enc_id",     32'(o_stall), 32'h07);
        drive(0, 1, 0, 0, 0, 0, 0, 0); cycle(); chk("enc_ex",     32'(o_stall), 32'h0F);
        drive(1, 0, 1, 0, 0, 0, 0, 0); cycle(); chk("enc_mem_id", 32'(o_stall), 32'h1F);
        idle(); cycle();

        // Branch while the PC is frozen is held and replayed on release.
        drive(0, 1, 0, 0, 32'h0, 0, 0, 0);     cycle(); chk("hold_bf0", 32'(o_bf), 32'h0);
        drive(0, 1, 0, 1, 32'h100, 0, 0, 0);   cycle(); chk("hold_bf1", 32'(o_bf), 32'h0);
        drive(0, 1, 0, 0, 32'h0, 0, 0, 0);     cycle(); chk("hold_pv2", 32'(o_pv), 32'h1);
        idle(); cycle();
        chk("hold_pv3", 32'(o_pv), 32'h1);
        chk("hold_bf3", 32'(o_bf), 32'h1);
        chk("hold_ba3", o_ba, 32'h0000_0100);
        cycle();
        chk("hold_pv4", 32'(o_pv), 32'h0);
        chk("hold_bf4", 32'(o_bf), 32'h0);

        // Exception over a memory stall with a held target.
        drive(0, 1, 0, 1, 32'h200, 0, 0, 0);       cycle();
        drive(0, 0, 1, 0, 32'h0, 1, 32'h180, 0);   cycle(); chk("exc_pv_before", 32'(o_pv), 32'h1);
        idle(); cycle();
        chk("exc_flush", 32'(o_flush), 32'h1);
        chk("exc_stall", 32'(o_stall), 32'h00);
        chk("exc_bf",    32'(o_bf),    32'h1);
        chk("exc_ba",    o_ba,         32'h0000_0180);
        chk("exc_pv",    32'(o_pv),    32'h0);
        cycle(); chk("exc_back_run", 32'(o_flush), 32'h0);

        // Watchdog: eight stalled cycles set it, seven do not.
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        repeat (MAXS) cycle();
        chk("wd_not_yet", 32'(o_to), 32'h0);
        idle(); cycle(); chk("wd_set",    32'(o_to), 32'h1);
        cycle();         chk("wd_sticky", 32'(o_to), 32'h1);
        drive(0, 0, 0, 0, 0, 0, 0, 1); cycle();
        idle(); cycle(); chk("wd_clr", 32'(o_to), 32'h0);
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        repeat (MAXS - 1) cycle();
        idle(); cycle(); chk("wd_seven", 32'(o_to), 32'h0);

        // Reset while flushing.
        drive(0, 1, 0, 1, 32'h300, 0, 0, 0);   cycle();
        drive(0, 0, 0, 0, 32'h0, 1, 32'h400, 0); cycle();
        idle(); cycle(); chk("rst_in_flush", 32'(o_flush), 32'h1);
        rst = 1'b0;
        cycle();
        chk("rst_stall", 32'(o_stall), 32'h3F);
        chk("rst_flush", 32'(o_flush), 32'h0);
        chk("rst_bf",    32'(o_bf),    32'h0);
        rst = 1'b1;
        cycle(); chk("reboot_stall0", 32'(o_stall), 32'h3F);
        cycle(); chk("reboot_stall1", 32'(o_stall), 32'h3F);
        cycle(); chk("reboot_bf",     32'(o_bf),    32'h0);
        chk("reboot_stall2", 32'(o_stall), 32'h00);

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 99) != 0);
            drive($urandom_range(0, 9) < 3, $urandom_range(0, 9) < 3, $urandom_range(0, 9) < 2,
                  $urandom_range(0, 4) == 0, $urandom, $urandom_range(0, 15) == 0, $urandom,
                  $urandom_range(0, 19) == 0);
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
